// File: rtl/uart_rx_control.sv
// uart_rx_control: oversampling UART receiver (idle-high line, one start bit,
// FRAME_SIZE data bits LSB first, one stop bit, no parity). Bit timing is
// counted in clk cycles; each good frame produces a one-cycle rx_valid strobe,
// and a low stop bit produces a one-cycle rx_frame_err strobe instead.
//
// Optional build macro: UART_RX_MAJORITY_EN -- each start/data/stop sample is
// the 2-of-3 majority of the synchronized line over the sample cycle and the
// two cycles before it. When undefined, each sample is the single value at
// the sample cycle.
module uart_rx_control #(
    parameter int unsigned BAUD_DIVISOR = 1024,
    parameter int unsigned FRAME_SIZE   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [FRAME_SIZE-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_frame_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIVISOR);
    localparam int unsigned IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUD_DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIVISOR - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_d;
    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_SIZE-1:0] shreg;
    logic                  sample;
    logic                  fall;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d2;

    // Two-flop synchronizer plus a two-deep history for edge detect and voting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            rx_d2   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            rx_d2   <= rx_d;
        end
    end

    // Majority vote over the sample cycle and the two cycles before it
    always_comb begin
        sample = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
    end
`else
    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Single-point sample of the synchronized line
    always_comb begin
        sample = rx_s;
    end
`endif

    // Falling edge of the synchronized line (previously 1, now 0)
    always_comb begin
        fall = rx_d & ~rx_s;
    end

    // Frame state machine, bit timing, shift register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sample ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= sample;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (sample) begin
                            // Leaving at mid stop bit leaves half a bit to catch
                            // an immediately following start edge
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed testbench for uart_rx_control with an expectation queue: each
// driven frame pushes its expected strobe (kind, data, cycle) and a monitor
// pops and compares when the DUT pulses rx_valid or rx_frame_err.
module tb_uart_rx_control;

    localparam int unsigned BD = 16;
    localparam int unsigned FS = 8;

    typedef struct packed {
        logic        err;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [FS-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;

    int   tests = 0;
    int   fails = 0;
    logic [31:0] cyc = '0;
    exp_t q[$];

    uart_rx_control #(
        .BAUD_DIVISOR(BD),
        .FRAME_SIZE  (FS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor: a strobe seen after posedge cyc belongs to edge cyc+1
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (rx_valid === 1'b1 || rx_frame_err === 1'b1)) begin
            exp_t e;
            check("exclusive_strobes", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_pulse: got valid=%0b err=%0b at cycle %0d, expected no pulse",
                       rx_valid, rx_frame_err, cyc + 32'd1);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                check("strobe_kind_err", {31'd0, rx_frame_err}, {31'd0, e.err});
                check("strobe_kind_valid", {31'd0, rx_valid}, {31'd0, ~e.err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("strobe_cycle", cyc + 32'd1, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a posedge; first value is sampled at the next edge (T0).
    // kind: 0 none, 1 rx_valid, 2 rx_frame_err. glitch_bit<0 disables the
    // one-cycle inversion; max_cycles<0 drives the whole frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch_bit,
                              input int max_cycles, input int kind, input logic [7:0] exp_data);
        logic [31:0] t0;
        exp_t        e;
        int          n;
        logic        bitv;
        logic        v;
        t0 = cyc + 32'd1;
        if (kind != 0) begin
            e.err  = (kind == 2);
            e.data = exp_data;
            e.cyc  = t0 + 32'd3 + 32'(BD / 2) + 32'((FS + 1) * BD);
            q.push_back(e);
        end
        n = 0;
        for (int b = 0; b < int'(FS) + 2; b++) begin
            if (b == 0) bitv = 1'b0;
            else if (b == int'(FS) + 1) bitv = stop_bit;
            else bitv = d[b-1];
            for (int j = 0; j < int'(BD); j++) begin
                if (max_cycles >= 0 && n >= max_cycles) return;
                v = bitv;
                if (glitch_bit >= 0 && b == glitch_bit + 1 && j == int'(BD / 2)) v = ~v;
                rx = v;
                n++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Plain frame
        send_frame(8'hA5, 1'b1, -1, -1, 1, 8'hA5);
        idle(10);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, -1, -1, 1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, -1, 1, 8'hFF);
        idle(10);

        // Short low glitch is rejected at mid start bit, then a real frame
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        send_frame(8'h3C, 1'b1, -1, -1, 1, 8'h3C);
        idle(10);

        // Bad stop bit, line held low: one error strobe, data held at 0x3C
        send_frame(8'h81, 1'b0, -1, -1, 2, 8'h3C);
        rx = 1'b0;
        idle(50);
        rx = 1'b1;
        idle(20);
        send_frame(8'h5A, 1'b1, -1, -1, 1, 8'h5A);
        idle(10);

        // Reset in the middle of data bit 3 of 0x55
        send_frame(8'h55, 1'b1, -1, int'(BD * 4 + BD / 2), 0, 8'h00);
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h12, 1'b1, -1, -1, 1, 8'h12);
        idle(10);

        // One-cycle inversion at the bit-2 sample point of 0x00
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b1, 2, -1, 1, 8'h00);
`else
        send_frame(8'h00, 1'b1, 2, -1, 1, 8'h04);
`endif
        idle(10);

        for (int i = 0; i < 600 && q.size() != 0; i++) idle(1);
        check("pending_expectations", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
